// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode encoding, ALU / result-select encodings, the
// E-register control struct and small opcode classification helpers used
// by the decode stage (decode_pipe) and its register file (regfile_p).
package decode_pkg;

  // Opcode field inst[15:12]; codes 9..F decode as NOP.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LW   = 4'h5,
    OP_SW   = 4'h6,
    OP_BEQ  = 4'h7,
    OP_JAL  = 4'h8
  } opcode_e;

  // ALU operation encodings carried on aluControlE.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Writeback result select carried on resultSrcE.
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC2 = 2'd2;

  // Control and index portion of the E register. The data operands are
  // DATA_W wide and live beside this struct in decode_pipe.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
    logic [1:0] result_src;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } e_ctrl_t;

  // True when the opcode consumes read port 1 (rs1).
  function automatic logic reads_rs1(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: reads_rs1 = 1'b1;
      default:                       reads_rs1 = 1'b0;
    endcase
  endfunction

  // True when the opcode consumes read port 2.
  function automatic logic reads_port2(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SW, OP_BEQ:                 reads_port2 = 1'b1;
      default:                       reads_port2 = 1'b0;
    endcase
  endfunction

  // Stores and branches compare/store the rd field, so port 2 reads rd.
  function automatic logic port2_uses_rd(input logic [3:0] op);
    port2_uses_rd = (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_pipe_regfile.sv
// regfile_p: NUM_REGS x DATA_W register file, two combinational read ports,
// one synchronous write port. Entry 0 reads as zero and ignores writes.
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle write to reads.
module regfile_p #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_en;

  // Writes to entry 0 are discarded so it stays zero forever.
  assign w_wr_en = i_we && (i_waddr != '0);

  // Storage: cleared by reset, written on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1: array read, optional same-cycle forward, zero for entry 0.
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
`ifdef DECODE_WB_BYPASS_EN
    if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
`else
    // Without forwarding a same-cycle read returns the pre-write contents.
`endif
    if (i_raddr1 == '0) o_rdata1 = '0;
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    o_rdata2 = r_regs[i_raddr2];
`ifdef DECODE_WB_BYPASS_EN
    if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
`else
    // Without forwarding a same-cycle read returns the pre-write contents.
`endif
    if (i_raddr2 == '0) o_rdata2 = '0;
  end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage. Splits a 16-bit instruction into
// fields, decodes controls and the sign-extended immediate, reads the
// register file (regfile_p) and registers everything into the E register.
// Also raises a combinational load-use stall request.
// Build option: DECODE_WB_BYPASS_EN (handled inside regfile_p) forwards a
// same-cycle writeback value to the register reads.
//
// Pipeline control: the E register has no valid/ready handshake. Each rising
// edge it resets (rst), loads a bubble (flushE), holds (stallD) or loads the
// decoded instruction, in that priority. validE marks a real instruction.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       inst,
  input  logic              instValid,
  input  logic [DATA_W-1:0] PCPlus2,
  input  logic [DATA_W-1:0] PCF,
  input  logic              regWriteWB,
  input  logic [3:0]        RdestW,
  input  logic [DATA_W-1:0] resultWB,
  input  logic              stallD,
  input  logic              flushE,
  output logic [DATA_W-1:0] PCPlus2E,
  output logic [DATA_W-1:0] PCE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] immExtE,
  output logic [3:0]        RdE,
  output logic [3:0]        Rs1E,
  output logic [3:0]        Rs2E,
  output logic              regWriteE,
  output logic              memWriteE,
  output logic              jumpE,
  output logic              branchE,
  output logic              aluSrcE,
  output logic              validE,
  output logic [2:0]        aluControlE,
  output logic [1:0]        resultSrcE,
  output logic              loadUseHazard
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [3:0]        w_op;
  logic [3:0]        w_src2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_imm;
  e_ctrl_t           w_dec;

  e_ctrl_t           r_e;
  logic [DATA_W-1:0] r_pc2;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;

  assign w_op   = inst[15:12];
  // Port 2 index: rd for stores and branches, rs2 otherwise.
  assign w_src2 = port2_uses_rd(w_op) ? inst[11:8] : inst[3:0];

  // Register file; index fields are truncated to their low AW bits.
  regfile_p #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (regWriteWB),
    .i_waddr  (RdestW[AW-1:0]),
    .i_wdata  (resultWB),
    .i_raddr1 (inst[4 +: AW]),
    .i_raddr2 (w_src2[AW-1:0]),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  // Control decode; a bubble (instValid=0) forces every control to 0.
  always_comb begin
    w_dec       = '0;
    w_dec.valid = instValid;
    w_dec.rd    = inst[11:8];
    w_dec.rs1   = inst[7:4];
    w_dec.rs2   = inst[3:0];
    case (w_op)
      OP_ADD: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_control = ALU_ADD;
      end
      OP_SUB: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_control = ALU_SUB;
      end
      OP_AND: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_control = ALU_AND;
      end
      OP_OR: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_control = ALU_OR;
      end
      OP_ADDI: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_src     = 1'b1;
        w_dec.alu_control = ALU_ADD;
      end
      OP_LW: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_src     = 1'b1;
        w_dec.alu_control = ALU_ADD;
        w_dec.result_src  = RES_MEM;
      end
      OP_SW: begin
        w_dec.mem_write   = 1'b1;
        w_dec.alu_src     = 1'b1;
        w_dec.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        w_dec.branch      = 1'b1;
        w_dec.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        w_dec.reg_write   = 1'b1;
        w_dec.jump        = 1'b1;
        w_dec.alu_src     = 1'b1;
        w_dec.alu_control = ALU_ADD;
        w_dec.result_src  = RES_PC2;
      end
      default: ;
    endcase
    if (!instValid) begin
      w_dec.reg_write   = 1'b0;
      w_dec.mem_write   = 1'b0;
      w_dec.jump        = 1'b0;
      w_dec.branch      = 1'b0;
      w_dec.alu_src     = 1'b0;
      w_dec.alu_control = ALU_ADD;
      w_dec.result_src  = RES_ALU;
    end
  end

  // Immediate select and sign extension to DATA_W.
  always_comb begin
    w_imm = '0;
    case (w_op)
      OP_ADDI, OP_LW, OP_SW: w_imm = {{(DATA_W-4){inst[3]}},  inst[3:0]};
      OP_BEQ:                w_imm = {{(DATA_W-4){inst[11]}}, inst[11:8]};
      OP_JAL:                w_imm = {{(DATA_W-8){inst[7]}},  inst[7:0]};
      default:               w_imm = '0;
    endcase
  end

  // E register: reset > flush (bubble, data zeroed) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      r_e   <= '0;
      r_pc2 <= '0;
      r_pc  <= '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_imm <= '0;
    end else if (!stallD) begin
      r_e   <= w_dec;
      r_pc2 <= PCPlus2;
      r_pc  <= PCF;
      r_rd1 <= w_rd1;
      r_rd2 <= w_rd2;
      r_imm <= w_imm;
    end
  end

  // A load in E whose destination is read through a port the decoding
  // instruction actually uses must stall that instruction.
  assign loadUseHazard = r_e.valid && (r_e.result_src == RES_MEM) &&
                         (r_e.rd != 4'd0) && instValid &&
                         ((reads_rs1(w_op)   && (inst[7:4] == r_e.rd)) ||
                          (reads_port2(w_op) && (w_src2    == r_e.rd)));

  assign PCPlus2E    = r_pc2;
  assign PCE         = r_pc;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign immExtE     = r_imm;
  assign RdE         = r_e.rd;
  assign Rs1E        = r_e.rs1;
  assign Rs2E        = r_e.rs2;
  assign regWriteE   = r_e.reg_write;
  assign memWriteE   = r_e.mem_write;
  assign jumpE       = r_e.jump;
  assign branchE     = r_e.branch;
  assign aluSrcE     = r_e.alu_src;
  assign validE      = r_e.valid;
  assign aluControlE = r_e.alu_control;
  assign resultSrcE  = r_e.result_src;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: table-driven decode vectors, directed multi-cycle
// sequences and a randomized run checked against a behavioural model.
// A second instance (DATA_W=32, NUM_REGS=8) shares the stimulus.
module tb_decode_pipe;

  localparam int DW = 16;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, instValid, regWriteWB, stallD, flushE;
  logic [15:0]   inst;
  logic [DW-1:0] PCPlus2, PCF, resultWB;
  logic [3:0]    RdestW;

  logic [DW-1:0] PCPlus2E, PCE, RD1E, RD2E, immExtE;
  logic [3:0]    RdE, Rs1E, Rs2E;
  logic          regWriteE, memWriteE, jumpE, branchE, aluSrcE, validE;
  logic [2:0]    aluControlE;
  logic [1:0]    resultSrcE;
  logic          loadUseHazard;

  logic [31:0]   w_pc2E, w_pcE, w_rd1E, w_rd2E, w_immE;
  logic [3:0]    w_RdE, w_Rs1E, w_Rs2E;
  logic          w_rwE, w_mwE, w_jE, w_bE, w_asE, w_vE, w_haz;
  logic [2:0]    w_aluE;
  logic [1:0]    w_rsE;

  decode_pipe #(.DATA_W(DW), .NUM_REGS(16)) u_dut (
    .clk(clk), .rst(rst), .inst(inst), .instValid(instValid),
    .PCPlus2(PCPlus2), .PCF(PCF), .regWriteWB(regWriteWB), .RdestW(RdestW),
    .resultWB(resultWB), .stallD(stallD), .flushE(flushE),
    .PCPlus2E(PCPlus2E), .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E), .immExtE(immExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .regWriteE(regWriteE),
    .memWriteE(memWriteE), .jumpE(jumpE), .branchE(branchE), .aluSrcE(aluSrcE),
    .validE(validE), .aluControlE(aluControlE), .resultSrcE(resultSrcE),
    .loadUseHazard(loadUseHazard)
  );

  decode_pipe #(.DATA_W(32), .NUM_REGS(8)) u_dut32 (
    .clk(clk), .rst(rst), .inst(inst), .instValid(instValid),
    .PCPlus2({16'h0, PCPlus2}), .PCF({16'h0, PCF}), .regWriteWB(regWriteWB),
    .RdestW(RdestW), .resultWB({16'h0, resultWB}), .stallD(stallD), .flushE(flushE),
    .PCPlus2E(w_pc2E), .PCE(w_pcE), .RD1E(w_rd1E), .RD2E(w_rd2E), .immExtE(w_immE),
    .RdE(w_RdE), .Rs1E(w_Rs1E), .Rs2E(w_Rs2E), .regWriteE(w_rwE),
    .memWriteE(w_mwE), .jumpE(w_jE), .branchE(w_bE), .aluSrcE(w_asE),
    .validE(w_vE), .aluControlE(w_aluE), .resultSrcE(w_rsE),
    .loadUseHazard(w_haz)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [DW-1:0] pc2, pc, rd1, rd2, imm;
    logic [3:0]    rd, rs1, rs2;
    logic          rw, mw, j, b, as, v;
    logic [2:0]    alu;
    logic [1:0]    rs;
  } e_t;

  e_t            exp_e;
  logic [DW-1:0] mdl_rf [16];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic e_t zero_e();
    e_t z;
    z.pc2 = '0; z.pc = '0; z.rd1 = '0; z.rd2 = '0; z.imm = '0;
    z.rd = '0; z.rs1 = '0; z.rs2 = '0;
    z.rw = 0; z.mw = 0; z.j = 0; z.b = 0; z.as = 0; z.v = 0;
    z.alu = '0; z.rs = '0;
    return z;
  endfunction

  // Sign-extend the low 'bits' bits of v to DW using plain integer math.
  function automatic logic [DW-1:0] sx(input int v, input int bits);
    int x;
    x = v & ((1 << bits) - 1);
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return DW'(x);
  endfunction

  function automatic logic [DW-1:0] rf_read(input logic [3:0] idx);
    if (idx == 0) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (regWriteWB && RdestW == idx) return resultWB;
`endif
    return mdl_rf[idx];
  endfunction

  function automatic int op_now();
    return int'(inst[15:12]);
  endfunction

  function automatic logic [3:0] port2_idx();
    return (op_now() == 6 || op_now() == 7) ? inst[11:8] : inst[3:0];
  endfunction

  function automatic logic exp_hazard();
    int  op;
    logic use1, use2;
    op   = op_now();
    use1 = (op <= 7);
    use2 = (op <= 3) || (op == 6) || (op == 7);
    return exp_e.v && (exp_e.rs == 2'd1) && (exp_e.rd != 0) && instValid &&
           ((use1 && inst[7:4] == exp_e.rd) || (use2 && port2_idx() == exp_e.rd));
  endfunction

  function automatic e_t mdl_next();
    e_t n;
    int op;
    if (rst || flushE) return zero_e();
    if (stallD) return exp_e;
    n = zero_e();
    op = op_now();
    n.pc2 = PCPlus2; n.pc = PCF; n.v = instValid;
    n.rd = inst[11:8]; n.rs1 = inst[7:4]; n.rs2 = inst[3:0];
    n.rd1 = rf_read(inst[7:4]);
    n.rd2 = rf_read(port2_idx());
    case (op)
      0: begin n.rw = 1; n.alu = 0; end
      1: begin n.rw = 1; n.alu = 1; end
      2: begin n.rw = 1; n.alu = 2; end
      3: begin n.rw = 1; n.alu = 3; end
      4: begin n.rw = 1; n.as = 1; n.imm = sx(int'(inst), 4); end
      5: begin n.rw = 1; n.as = 1; n.rs = 1; n.imm = sx(int'(inst), 4); end
      6: begin n.mw = 1; n.as = 1; n.imm = sx(int'(inst), 4); end
      7: begin n.b = 1; n.alu = 1; n.imm = sx(int'(inst) >> 8, 4); end
      8: begin n.rw = 1; n.j = 1; n.as = 1; n.rs = 2; n.imm = sx(int'(inst), 8); end
      default: ;
    endcase
    if (!instValid) begin
      n.rw = 0; n.mw = 0; n.b = 0; n.j = 0; n.as = 0; n.alu = 0; n.rs = 0;
    end
    return n;
  endfunction

  task automatic compare_e();
    check("PCPlus2E", PCPlus2E, exp_e.pc2);
    check("PCE", PCE, exp_e.pc);
    check("RD1E", RD1E, exp_e.rd1);
    check("RD2E", RD2E, exp_e.rd2);
    check("immExtE", immExtE, exp_e.imm);
    check("RdE", RdE, exp_e.rd);
    check("Rs1E", Rs1E, exp_e.rs1);
    check("Rs2E", Rs2E, exp_e.rs2);
    check("regWriteE", regWriteE, exp_e.rw);
    check("memWriteE", memWriteE, exp_e.mw);
    check("jumpE", jumpE, exp_e.j);
    check("branchE", branchE, exp_e.b);
    check("aluSrcE", aluSrcE, exp_e.as);
    check("validE", validE, exp_e.v);
    check("aluControlE", aluControlE, exp_e.alu);
    check("resultSrcE", resultSrcE, exp_e.rs);
  endtask

  // ---------------- driver ----------------
  // Inputs are set just after a rising edge; this task checks the hazard
  // output mid-cycle, advances the model, crosses one edge, compares E.
  task automatic cycle();
    e_t nx;
    #1;
    if (!rst) check("loadUseHazard", loadUseHazard, exp_hazard());
    nx = mdl_next();
    if (rst) begin
      for (int i = 0; i < 16; i++) mdl_rf[i] = '0;
    end else if (regWriteWB && RdestW != 0) begin
      mdl_rf[RdestW] = resultWB;
    end
    @(posedge clk);
    #1;
    exp_e = nx;
    compare_e();
  endtask

  task automatic set_in(input logic [15:0] i, input logic v);
    inst = i; instValid = v;
    PCF = DW'($urandom); PCPlus2 = PCF + DW'(2);
  endtask

  task automatic set_wb(input logic en, input logic [3:0] idx, input logic [DW-1:0] d);
    regWriteWB = en; RdestW = idx; resultWB = d;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [15:0]   inst;
    logic          valid;
    logic          rw, mw, b, j, as;
    logic [2:0]    alu;
    logic [1:0]    rs;
    logic [DW-1:0] imm;
    logic          chk_imm;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [15:0] i, input logic v,
                              input logic rw, input logic mw, input logic b,
                              input logic j, input logic as, input logic [2:0] alu,
                              input logic [1:0] rs, input logic [DW-1:0] imm,
                              input logic ci);
    vec_t t;
    t.inst = i; t.valid = v; t.rw = rw; t.mw = mw; t.b = b; t.j = j;
    t.as = as; t.alu = alu; t.rs = rs; t.imm = imm; t.chk_imm = ci;
    return t;
  endfunction

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [DW-1:0] EXP_BYP = 16'hBEEF;
`else
  localparam logic [DW-1:0] EXP_BYP = 16'h0000;
`endif

  // ---------------- test sequence ----------------
  initial begin
    exp_e = zero_e();
    for (int i = 0; i < 16; i++) mdl_rf[i] = '0;
    rst = 1; stallD = 0; flushE = 0;
    set_in(16'h0000, 1'b0);
    set_wb(1'b0, 4'd0, '0);

    vecs[0]  = mk(16'h0123, 1, 1,0,0,0,0, 3'd0, 2'd0, 16'h0000, 1);
    vecs[1]  = mk(16'h1123, 1, 1,0,0,0,0, 3'd1, 2'd0, 16'h0000, 1);
    vecs[2]  = mk(16'h2123, 1, 1,0,0,0,0, 3'd2, 2'd0, 16'h0000, 1);
    vecs[3]  = mk(16'h3123, 1, 1,0,0,0,0, 3'd3, 2'd0, 16'h0000, 1);
    vecs[4]  = mk(16'h412F, 1, 1,0,0,0,1, 3'd0, 2'd0, 16'hFFFF, 1);
    vecs[5]  = mk(16'h5127, 1, 1,0,0,0,1, 3'd0, 2'd1, 16'h0007, 1);
    vecs[6]  = mk(16'h6128, 1, 0,1,0,0,1, 3'd0, 2'd0, 16'hFFF8, 1);
    vecs[7]  = mk(16'h7A12, 1, 0,0,1,0,0, 3'd1, 2'd0, 16'hFFFA, 1);
    vecs[8]  = mk(16'h807F, 1, 1,0,0,1,1, 3'd0, 2'd2, 16'h007F, 1);
    vecs[9]  = mk(16'h9FFF, 1, 0,0,0,0,0, 3'd0, 2'd0, 16'h0000, 1);
    vecs[10] = mk(16'hC555, 1, 0,0,0,0,0, 3'd0, 2'd0, 16'h0000, 1);
    vecs[11] = mk(16'hFFFF, 1, 0,0,0,0,0, 3'd0, 2'd0, 16'h0000, 1);
    vecs[12] = mk(16'h5127, 0, 0,0,0,0,0, 3'd0, 2'd0, 16'h0000, 0);
    vecs[13] = mk(16'h80FE, 0, 0,0,0,0,0, 3'd0, 2'd0, 16'h0000, 0);

    // Reset held for two edges: every output zero, no hazard.
    cycle();
    cycle();
    check("rst_validE", validE, 1'b0);
    check("rst_RD1E", RD1E, 16'h0);
    check("rst_resultSrcE", resultSrcE, 2'd0);
    rst = 0;
    #1;
    check("rst_hazard", loadUseHazard, 1'b0);

    // Table-driven decode vectors.
    for (int k = 0; k < 14; k++) begin
      set_in(vecs[k].inst, vecs[k].valid);
      cycle();
      check("vec_regWriteE", regWriteE, vecs[k].rw);
      check("vec_memWriteE", memWriteE, vecs[k].mw);
      check("vec_branchE", branchE, vecs[k].b);
      check("vec_jumpE", jumpE, vecs[k].j);
      check("vec_aluSrcE", aluSrcE, vecs[k].as);
      check("vec_aluControlE", aluControlE, vecs[k].alu);
      check("vec_resultSrcE", resultSrcE, vecs[k].rs);
      check("vec_validE", validE, vecs[k].valid);
      if (vecs[k].chk_imm) check("vec_immExtE", immExtE, vecs[k].imm);
    end

    // WB write r1, then ADD r0,r1,r2 reads it.
    set_wb(1'b1, 4'd1, 16'h0010); set_in(16'h0000, 1'b0);
    cycle();
    set_wb(1'b0, 4'd0, '0); set_in(16'h0012, 1'b1);
    cycle();
    check("add_RD1E", RD1E, 16'h0010);
    check("add_regWriteE", regWriteE, 1'b1);
    check("add_aluControlE", aluControlE, 3'b000);
    check("add_RdE", RdE, 4'd0);

    // Same-cycle WB write and read of r3.
    set_wb(1'b1, 4'd3, 16'hBEEF); set_in(16'h4034, 1'b1);
    cycle();
    check("byp_RD1E", RD1E, EXP_BYP);
    check("byp_immExtE", immExtE, 16'h0004);

    // Load-use: LW r2 then ADD r0,r2,r3; flush+stall together -> bubble.
    set_wb(1'b0, 4'd0, '0); set_in(16'h5210, 1'b1);
    cycle();
    set_in(16'h0023, 1'b1);
    #1;
    check("lu_hazard", loadUseHazard, 1'b1);
    stallD = 1; flushE = 1;
    cycle();
    check("lu_flush_validE", validE, 1'b0);
    check("lu_flush_regWriteE", regWriteE, 1'b0);
    check("lu_flush_resultSrcE", resultSrcE, 2'd0);
    check("lu_after_hazard", loadUseHazard, 1'b0);
    stallD = 0; flushE = 0;

    // JAL immediate (also r15 written), then SW reads r15 via port 2.
    set_wb(1'b1, 4'hF, 16'h1234); set_in(16'h80FE, 1'b1);
    cycle();
    check("jal_immExtE", immExtE, 16'hFFFE);
    check("jal_jumpE", jumpE, 1'b1);
    check("jal_resultSrcE", resultSrcE, 2'd2);
    check("jal32_immExtE", w_immE, 32'hFFFF_FFFE);
    set_wb(1'b0, 4'd0, '0); set_in(16'h6F12, 1'b1);
    cycle();
    check("sw_RD2E", RD2E, 16'h1234);
    check("sw_memWriteE", memWriteE, 1'b1);
    check("sw_regWriteE", regWriteE, 1'b0);
    check("sw32_RD2E", w_rd2E, 32'h0000_1234);
    check("sw32_immExtE", w_immE, 32'h0000_0002);

    // Stall for three cycles while inst changes: E holds SUB r3,r4,r5.
    set_in(16'h1345, 1'b1);
    cycle();
    stallD = 1;
    for (int k = 0; k < 3; k++) begin
      set_in(16'($urandom), 1'($urandom));
      cycle();
      check("stall_RdE", RdE, 4'd3);
      check("stall_Rs1E", Rs1E, 4'd4);
      check("stall_aluControlE", aluControlE, 3'd1);
      check("stall32_aluControlE", w_aluE, 3'd1);
    end

    // Reset during a stall drops the held instruction and clears the RF.
    rst = 1;
    cycle();
    check("rststall_validE", validE, 1'b0);
    check("rststall_RdE", RdE, 4'd0);
    rst = 0; stallD = 0;
    set_in(16'h0010, 1'b1);
    cycle();
    check("rststall_rf_cleared", RD1E, 16'h0000);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst    = ($urandom_range(0, 99) == 0);
      flushE = ($urandom_range(0, 9) == 0);
      stallD = ($urandom_range(0, 6) == 0);
      set_in(16'($urandom), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 1) == 1) inst[7:4] = exp_e.rd;
      if ($urandom_range(0, 3) == 0) inst[15:12] = 4'd5;
      set_wb(1'($urandom), 4'($urandom), DW'($urandom));
      cycle();
    end
    rst = 0; stallD = 0; flushE = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, datapath width (8..32).
REQ-002 The block SHALL have parameter NUM_REGS, default 16, architectural registers (power of two, 2..16); register index fields wider than log2(NUM_REGS) SHALL use their low bits only.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  sole clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- inst  in  16  fetched instruction.
- instValid  in  1  inst is real (0 = bubble).
- PCPlus2  in  DATA_W  fetch PC + 2.
- PCF  in  DATA_W  fetch PC.
- regWriteWB  in  1  writeback enable.
- RdestW  in  4  writeback register.
- resultWB  in  DATA_W  writeback data.
- stallD  in  1  hold the E register.
- flushE  in  1  load a bubble into the E register.
- PCPlus2E, PCE, RD1E, RD2E, immExtE  out  DATA_W  registered operands.
- RdE, Rs1E, Rs2E  out  4  registered register indices.
- regWriteE, memWriteE, jumpE, branchE, aluSrcE, validE  out  1  registered controls.
- aluControlE  out  3  registered ALU operation.
- resultSrcE  out  2  registered result select: 0 ALU, 1 memory, 2 PC+2.
- loadUseHazard  out  1  combinational stall request.

Function
REQ-004 Instruction fields: op=inst[15:12], rd=inst[11:8], rs1=inst[7:4], rs2=inst[3:0].
REQ-005 Decode table (regWrite, memWrite, branch, jump, aluSrc, aluControl, resultSrc):
- 0 ADD: 1,0,0,0,0,000,0
- 1 SUB: 1,0,0,0,0,001,0
- 2 AND: 1,0,0,0,0,010,0
- 3 OR: 1,0,0,0,0,011,0
- 4 ADDI: 1,0,0,0,1,000,0
- 5 LW: 1,0,0,0,1,000,1
- 6 SW: 0,1,0,0,1,000,0
- 7 BEQ: 0,0,1,0,0,001,0
- 8 JAL: 1,0,0,1,1,000,2
- 9-F: all zero (NOP).
REQ-006 Immediate SHALL be sign-extended to DATA_W: ADDI/LW/SW use inst[3:0]; BEQ uses inst[11:8]; JAL uses inst[7:0]. All other opcodes SHALL produce 0.
REQ-007 Read port 1 SHALL read rs1. Read port 2 SHALL read rd for SW and BEQ, and rs2 otherwise. Register index 0 SHALL always read 0 and SHALL ignore writes.
REQ-008 The register file SHALL write resultWB to RdestW on a rising clk edge when regWriteWB=1 and RdestW!=0.
REQ-009 With instValid=0 the decoded controls SHALL all be forced to 0.
REQ-010 The E register SHALL update every rising edge with priority rst > flushE > stallD > load.
- flushE: all controls 0 and validE=0; data fields don't-care but SHALL be zeroed.
- stallD (and no flush): all E outputs hold.
- Load latency: exactly 1 cycle from inst to the E outputs.
REQ-011 loadUseHazard SHALL be 1 when all of the following hold: validE=1; resultSrcE=1; RdE!=0; instValid=1; the current instruction reads RdE through a used read port. Unused ports SHALL be ignored (JAL and NOP read none; ADDI and LW read rs1 only).
REQ-012 Simultaneous flushE and stallD: flush SHALL win.

Reset
REQ-013 On a rising edge with rst=1, every registered output and every register-file entry SHALL become 0; loadUseHazard SHALL then be 0.
REQ-014 rst asserted mid-stall SHALL clear state; the held instruction SHALL be lost.

Configuration
REQ-015 Macro DECODE_WB_BYPASS_EN: when defined, a read in the same cycle as a matching WB write (same index, regWriteWB=1, index!=0) SHALL return resultWB. When undefined, such a read SHALL return the pre-write value.

Structure
REQ-016 Package decode_pkg SHALL hold the opcode enum, the aluControl and resultSrc encodings, and the E-register struct typedef.
REQ-017 The register file SHALL be sub-module regfile_p (parameters DATA_W and NUM_REGS, bypass per REQ-015); decode logic and the E register SHALL reside in decode_pipe.

Verification
REQ-018 rst=1 for 2 cycles -> every output 0, validE=0.
REQ-019 WB writes r1=0x0010; next cycle inst=16'h0012 (ADD r0,r1,r2) -> after 1 edge RD1E=0x0010, regWriteE=1, aluControlE=000, RdE=0.
REQ-020 Same-cycle WB write r3=0xBEEF with inst=16'h4034 (ADDI r0,r3,4): with DECODE_WB_BYPASS_EN -> RD1E=0xBEEF; without it -> RD1E=0; immExtE=0x0004 in both cases.
REQ-021 inst=16'h5210 (LW r2,r1,0) loaded, then inst=16'h0023 -> loadUseHazard=1; with stallD=1, flushE=1 for one edge -> validE=0 and controls 0.
REQ-022 inst=16'h80FE (JAL r0,-2) -> immExtE=0xFFFE, jumpE=1, resultSrcE=2; inst=16'h6F12 (SW) -> RD2E reads rF, memWriteE=1, regWriteE=0.
REQ-023 stallD=1 held 3 cycles while inst changes -> E outputs constant; with DATA_W=32, NUM_REGS=8 -> same results, immediates sign-extended to 32 bits.
